// File: rtl/word_serializer.sv
// Parallel-in, serial-out word reader: accepts a WIDTH-bit word on load/ready
// and presents it one bit per consumer step, pulsing done after the last bit.
module word_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk_i,
   input  logic             clrn_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             load_i,
   output logic             ready_o,
   input  logic             e_i,
   output logic             so_o,
   output logic             sv_o,
   output logic             done_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sreg_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;

   // The shift register is cleared on word completion so so_o idles low.
   always_ff @(posedge clk_i) begin
      if (!clrn_i) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load_i) begin
                  sreg_q  <= d_i;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (e_i) begin
                  if (cnt_q == LAST_BIT) begin
                     done_q  <= 1'b1;
                     sreg_q  <= '0;
                     state_q <= IDLE;
                  end else begin
                     sreg_q <= MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
                     cnt_q  <= cnt_q + CNT_W'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_o = (state_q == IDLE);
   assign sv_o    = (state_q == SHIFT);
   assign so_o    = sv_o & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
   assign done_o  = done_q;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: LSB-first and MSB-first instances share stimulus
// and are compared every cycle against a bit-queue reference model.
module tb_word_serializer;

   logic       clk = 1'b0;
   logic       clrn;
   logic [7:0] d;
   logic       load;
   logic       e;

   logic readyL, soL, svL, doneL;
   logic readyM, soM, svM, doneM;

   int checks = 0;
   int errors = 0;

   // Reference state: bits still to be sent, in transmission order.
   bit qL[$];
   bit qM[$];
   bit busyL = 1'b0, busyM = 1'b0;
   bit expDoneL = 1'b0, expDoneM = 1'b0;

   int svCount   = 0;
   int doneCount = 0;

   always #5 clk = ~clk;

   word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
      .clk_i  (clk),
      .clrn_i (clrn),
      .d_i    (d),
      .load_i (load),
      .ready_o(readyL),
      .e_i    (e),
      .so_o   (soL),
      .sv_o   (svL),
      .done_o (doneL)
   );

   word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
      .clk_i  (clk),
      .clrn_i (clrn),
      .d_i    (d),
      .load_i (load),
      .ready_o(readyM),
      .e_i    (e),
      .so_o   (soM),
      .sv_o   (svM),
      .done_o (doneM)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   // Advance the reference by one clock edge using the inputs seen at that edge.
   task automatic modelEdge();
      if (!clrn) begin
         qL.delete();
         qM.delete();
         busyL    = 1'b0;
         busyM    = 1'b0;
         expDoneL = 1'b0;
         expDoneM = 1'b0;
      end else begin
         expDoneL = 1'b0;
         expDoneM = 1'b0;
         if (!busyL) begin
            if (load) begin
               for (int i = 0; i < 8; i++) qL.push_back(d[i]);
               busyL = 1'b1;
            end
         end else if (e) begin
            void'(qL.pop_front());
            if (qL.size() == 0) begin
               busyL    = 1'b0;
               expDoneL = 1'b1;
            end
         end
         if (!busyM) begin
            if (load) begin
               for (int i = 7; i >= 0; i--) qM.push_back(d[i]);
               busyM = 1'b1;
            end
         end else if (e) begin
            void'(qM.pop_front());
            if (qM.size() == 0) begin
               busyM    = 1'b0;
               expDoneM = 1'b1;
            end
         end
      end
   endtask

   task automatic compareAll();
      checkOutput("readyL", readyL, !busyL);
      checkOutput("svL",    svL,    busyL);
      checkOutput("soL",    soL,    busyL ? qL[0] : 1'b0);
      checkOutput("doneL",  doneL,  expDoneL);
      checkOutput("readyM", readyM, !busyM);
      checkOutput("svM",    svM,    busyM);
      checkOutput("soM",    soM,    busyM ? qM[0] : 1'b0);
      checkOutput("doneM",  doneM,  expDoneM);
      if (svL)   svCount++;
      if (doneL) doneCount++;
   endtask

   // Drive one cycle of inputs, step the model at the edge, check mid-cycle.
   task automatic applyStimulus(input logic c, input logic [7:0] dv, input logic l, input logic ev);
      clrn = c;
      d    = dv;
      load = l;
      e    = ev;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      compareAll();
   endtask

   initial begin
      clrn = 1'b0;
      d    = '0;
      load = 1'b0;
      e    = 1'b0;

      // Reset with random inputs, then idle cycles with e wiggling.
      repeat (2) applyStimulus(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      repeat (3) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'($urandom));

      // 8'hC1 with e held high.
      applyStimulus(1'b1, 8'hC1, 1'b1, 1'b1);
      repeat (10) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b1);

      // 8'hC1 with e toggling 1,0,1,0...
      applyStimulus(1'b1, 8'hC1, 1'b1, 1'b0);
      for (int i = 0; i < 18; i++) applyStimulus(1'b1, 8'h00, 1'b0, (i % 2) == 0);

      // Load of 8'h0F attempted while 8'hF0 is shifting.
      applyStimulus(1'b1, 8'hF0, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'h0F, (i < 6), 1'b1);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);

      // Back-to-back: 8'h55 loaded in the done cycle of 8'hAA.
      svCount   = 0;
      doneCount = 0;
      applyStimulus(1'b1, 8'hAA, 1'b1, 1'b1);
      repeat (8) applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
      checkOutput("b2bDoneCycle", doneL, 1'b1);
      applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
      checkOutput("b2bFirstBit", soL, 1'b1);
      repeat (8) applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
      checkOutput("b2bValidBits", svCount, 16);
      checkOutput("b2bDonePulses", doneCount, 2);

      // Mid-word reset after three bits of 8'hFF, then 8'h01.
      applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
      repeat (3) applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("rstSv",    svL,    1'b0);
      checkOutput("rstReady", readyL, 1'b1);
      checkOutput("rstDone",  doneL,  1'b0);
      applyStimulus(1'b1, 8'h01, 1'b1, 1'b1);
      repeat (9) applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++)
         applyStimulus(($urandom_range(0, 29) != 0), 8'($urandom), 1'($urandom), 1'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
